// File: rtl/divider_block_pkg.sv
// Ratios, half-periods and counter widths shared by the divider_block slice.
package divider_block_pkg;

  localparam int RATIO4  = 4;
  localparam int RATIO8  = 8;
  localparam int RATIO9  = 9;
  localparam int RATIO12 = 12;
  localparam int RATIO80 = 80;

  localparam int NUM_EVEN = 4;

  localparam int HALF [NUM_EVEN] = '{RATIO4/2, RATIO8/2, RATIO12/2, RATIO80/2};

  // A single-bit counter would make the wrap compare degenerate; floor the width at 2.
  function automatic int cnt_w(input int half);
    return (half < 4) ? 2 : $clog2(half);
  endfunction

  localparam int CNT_W [NUM_EVEN] = '{cnt_w(HALF[0]), cnt_w(HALF[1]),
                                      cnt_w(HALF[2]), cnt_w(HALF[3])};

  localparam int CNT9_W  = 4;
  localparam int DIV9_HI = 4;

endpackage

// File: rtl/even_clk_div.sv
// Even-ratio 50 % divider: counts 0..HALF-1 and toggles its output on the wrap.
module even_clk_div #(
  parameter int HALF = 2,
  parameter int W    = 2
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == W'(HALF - 1)) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/divider_block.sv
// Fixed /4, /8, /9, /12, /80 clock divider, all 50 % duty and phase-aligned at reset.
// Optional VDD/VSS pins with DIVIDER_BLOCK_POWER_PINS_EN.
module divider_block
  import divider_block_pkg::*;
(
`ifdef DIVIDER_BLOCK_POWER_PINS_EN
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic clk,
  input  logic reset,
  output logic div4,
  output logic div8,
  output logic div9,
  output logic div12,
  output logic div80
);

  logic [NUM_EVEN-1:0] even_q;

  for (genvar g = 0; g < NUM_EVEN; g++) begin : g_even
    even_clk_div #(
      .HALF (HALF[g]),
      .W    (CNT_W[g])
    ) u_div (
      .clk     (clk),
      .reset   (reset),
      .clk_out (even_q[g])
    );
  end

  assign div4  = even_q[0];
  assign div8  = even_q[1];
  assign div12 = even_q[2];
  assign div80 = even_q[3];

  logic [CNT9_W-1:0] cnt9;
  logic              p9;
  logic              n9;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt9 <= '0;
      p9   <= 1'b0;
    end else begin
      cnt9 <= (cnt9 == CNT9_W'(RATIO9 - 1)) ? '0 : cnt9 + 1'b1;
      p9   <= (cnt9 < CNT9_W'(DIV9_HI));
    end
  end

  // Half-cycle delayed copy stretches the 4-cycle pulse to 4.5 cycles.
  always_ff @(negedge clk) begin
    if (reset) n9 <= 1'b0;
    else       n9 <= p9;
  end

  assign div9 = p9 | n9;

endmodule

// File: tb/tb_divider_block.sv
// Randomized-reset bench for divider_block against a cycle-index reference model.
module tb_divider_block;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic div4, div8, div9, div12, div80;
`ifdef DIVIDER_BLOCK_POWER_PINS_EN
  wire VDD;
  wire VSS;
`endif

  divider_block dut (
`ifdef DIVIDER_BLOCK_POWER_PINS_EN
    .VDD   (VDD),
    .VSS   (VSS),
`endif
    .clk   (clk),
    .reset (reset),
    .div4  (div4),
    .div8  (div8),
    .div9  (div9),
    .div12 (div12),
    .div80 (div80)
  );

  always #5 clk = ~clk;

  int   vecs = 0;
  int   errs = 0;
  int   k    = 0;
  bit   started = 0;
  bit   cnt_en  = 0;
  int   edges [5];
  logic [4:0] prev;

  // divN after posedge k is high in odd half-period blocks.
  function automatic logic exp_even(input int kk, input int half);
    return ((kk / half) % 2) == 1;
  endfunction

  // div9 in half-cycle units h: high for 9 of every 18, starting at h=2.
  function automatic logic exp_div9(input int h);
    return (h >= 2) && (((h - 2) % 18) < 9);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s k=%0d t=%0t got %b want %b", name, k, $time, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    vecs++;
    if (act < lo || act > hi) begin
      errs++;
      $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_all(input int h, input int kk);
    logic [4:0] cur;
    chk("div4",  div4,  exp_even(kk, 2));
    chk("div8",  div8,  exp_even(kk, 4));
    chk("div12", div12, exp_even(kk, 6));
    chk("div80", div80, exp_even(kk, 40));
    chk("div9",  div9,  exp_div9(h));
    cur = {div80, div12, div9, div8, div4};
    if (cnt_en)
      for (int i = 0; i < 5; i++)
        if (cur[i] !== prev[i]) edges[i]++;
    prev = cur;
  endtask

  always @(posedge clk) begin
    if (reset) k = 0;
    else       k = k + 1;
    started = 1;
    #1 check_all(2 * k, k);
  end

  always @(negedge clk) begin
    if (started) begin
      #1 check_all(2 * k + 1, k);
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_div4"},  div4,  1'b0);
    chk({name, "_div8"},  div8,  1'b0);
    chk({name, "_div9"},  div9,  1'b0);
    chk({name, "_div12"}, div12, 1'b0);
    chk({name, "_div80"}, div80, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk_all_zero("rst");
    @(negedge clk);
    #2 chk("rst_n9", div9, 1'b0);

    // release and pin the first few edges with literals
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (edges[i]) edges[i] = 0;
    prev   = '0;
    cnt_en = 1'b1;
    @(posedge clk); #2;                   // k=1
    chk("lit_div9_k1", div9, 1'b1);
    chk("lit_div4_k1", div4, 1'b0);
    @(posedge clk); #2 chk("lit_div4_k2", div4, 1'b1);
    @(posedge clk); #2 chk("lit_div4_k3", div4, 1'b1);
    @(posedge clk); #2 chk("lit_div4_k4", div4, 1'b0);
    @(posedge clk); #2;                   // k=5
    chk("lit_div4_k5", div4, 1'b0);
    chk("lit_div9_k5", div9, 1'b1);
    @(negedge clk); #2 chk("lit_div9_fall", div9, 1'b0);
    repeat (995) @(posedge clk);          // up to k=1000
    #2 cnt_en = 1'b0;
    chk_rng("edges_div4",  edges[0], 499, 501);
    chk_rng("edges_div8",  edges[1], 249, 251);
    chk_rng("edges_div9",  edges[2], 221, 223);
    chk_rng("edges_div12", edges[3], 165, 167);
    chk_rng("edges_div80", edges[4], 24, 26);

    // fresh run, one-cycle reset at cycle 37
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (37) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_all_zero("rst37");
    repeat (200) @(posedge clk);

    // randomized run lengths and reset pulse widths
    for (int it = 0; it < 8; it++) begin
      int run_len, rst_len;
      run_len = $urandom_range(1, 300);
      rst_len = $urandom_range(1, 3);
      repeat (run_len) @(posedge clk);
      #1 reset = 1'b1;
      repeat (rst_len) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (100) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
